// File: rtl/fp_to_int_converter.sv
// IEEE-754 single-precision to signed 32-bit integer converter.
// Serial alignment (one bit per cycle) followed by a single rounding cycle.
module fp_to_int_converter (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        a,
    input  logic [1:0]         round_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] d,
    output logic               invalid,
    output logic               inexact
);

    typedef enum logic [1:0] {IDLE, ALIGN, ROUND, DONE} state_t;

    state_t      state;
    logic        sign;
    logic        go_left;
    logic        guard;
    logic        sticky;
    logic [1:0]  rm;
    logic [31:0] mag;
    logic [4:0]  cnt;

    logic [7:0]  e;
    logic [22:0] f;
    logic [23:0] m;
    logic [7:0]  eff_e;
    logic [7:0]  right_n;
    logic [4:0]  right_cnt;
    logic [4:0]  left_cnt;
    logic        special;
    logic [31:0] special_d;
    logic        special_inv;
    logic        inc;
    logic [31:0] sum;

    assign in_ready = (state == IDLE);

    assign e         = a[30:23];
    assign f         = a[22:0];
    assign m         = {|e, f};
    assign eff_e     = (e == 8'd0) ? 8'd1 : e;
    assign right_n   = 8'd150 - eff_e;
    assign right_cnt = (right_n > 8'd25) ? 5'd25 : right_n[4:0];
    // e is 150..157 on the left path, so the low five bits minus 22 give e - 150
    assign left_cnt  = e[4:0] - 5'd22;

    always_comb begin
        special     = 1'b1;
        special_d   = 32'h8000_0000;
        special_inv = 1'b1;
        if (e == 8'hFF) begin
            special_d = (f == 23'd0 && !a[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
        end else if (!a[31] && e >= 8'd158) begin
            special_d = 32'h7FFF_FFFF;
        end else if (a[31] && (e > 8'd158 || (e == 8'd158 && f != 23'd0))) begin
            special_d = 32'h8000_0000;
        end else if (a[31] && e == 8'd158) begin
            // exactly -2^31 is representable
            special_inv = 1'b0;
        end else begin
            special = 1'b0;
        end
    end

    function automatic logic round_inc(input logic [1:0] mode, input logic s,
                                       input logic g, input logic st, input logic lsb);
        case (mode)
            2'b00:   round_inc = g & (st | lsb);
            2'b01:   round_inc = (g | st) & s;
            2'b10:   round_inc = (g | st) & ~s;
            default: round_inc = 1'b0;
        endcase
    endfunction

    assign inc = round_inc(rm, sign, guard, sticky, mag[0]);
    assign sum = mag + {31'd0, inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            d         <= '0;
            invalid   <= 1'b0;
            inexact   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign   <= a[31];
                        rm     <= round_mode;
                        guard  <= 1'b0;
                        sticky <= 1'b0;
                        mag    <= {8'd0, m};
                        if (special) begin
                            d         <= special_d;
                            invalid   <= special_inv;
                            inexact   <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else if (e >= 8'd150) begin
                            go_left <= 1'b1;
                            cnt     <= left_cnt;
                            state   <= ALIGN;
                        end else begin
                            go_left <= 1'b0;
                            cnt     <= right_cnt;
                            state   <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    if (cnt != 5'd0) begin
                        if (go_left) begin
                            mag <= mag << 1;
                        end else begin
                            sticky <= sticky | guard;
                            guard  <= mag[0];
                            mag    <= mag >> 1;
                        end
                    end
                    // the last shift and the exit happen on the same edge
                    if (cnt <= 5'd1) begin
                        state <= ROUND;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                ROUND: begin
                    d         <= sign ? -$signed(sum) : $signed(sum);
                    invalid   <= 1'b0;
                    inexact   <= guard | sticky;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
